// File: rtl/nmi_rr_arbiter.sv
// Round-robin arbiter sharing one nmi master port between N requesters.
// Latches the winning request, holds it until the slave answers or a timeout fires.
module nmi_rr_arbiter #(
    parameter int unsigned N           = 2,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [N-1:0]          req_valid_i,
    input  logic [N-1:0][31:0]    req_addr_i,
    input  logic [N-1:0][31:0]    req_wdata_i,
    input  logic [N-1:0][3:0]     req_wstrb_i,
    output logic [N-1:0]          req_ready_o,
    output logic [31:0]           req_rdata_o,
    output logic                  nmi_valid_o,
    output logic [31:0]           nmi_addr_o,
    output logic [31:0]           nmi_wdata_o,
    output logic [3:0]            nmi_wstrb_o,
    input  logic                  nmi_ready_i,
    input  logic [31:0]           nmi_rdata_i,
    output logic                  timeout_o,
    output logic                  busy_o
);

    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            found;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   idx;
    logic            tmo_hit;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = GW'((32'(last_q) + i) % N);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        req_rdata_o = '0;
        nmi_valid_o = 1'b0;
        timeout_o   = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = winner;
                    addr_d  = req_addr_i[winner];
                    wdata_d = req_wdata_i[winner];
                    wstrb_d = req_wstrb_i[winner];
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                nmi_valid_o = 1'b1;
                busy_o      = 1'b1;
                // Ready takes priority over a coincident timeout.
                if (nmi_ready_i) begin
                    req_ready_o[grant_q] = 1'b1;
                    req_rdata_o          = nmi_rdata_i;
                    last_d               = grant_q;
                    state_d              = StIdle;
                end else if (tmo_hit) begin
                    req_ready_o[grant_q] = 1'b1;
                    req_rdata_o          = ERR_DATA;
                    timeout_o            = 1'b1;
                    last_d               = grant_q;
                    state_d              = StIdle;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= GW'(N - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign nmi_addr_o  = addr_q;
    assign nmi_wdata_o = wdata_q;
    assign nmi_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// Bench for nmi_rr_arbiter: directed scenarios then randomized transactions,
// checked against a transaction-level round-robin model.
module tb_nmi_rr_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned GW = 1;
    localparam int unsigned TO = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0][31:0]  req_addr;
    logic [N-1:0][31:0]  req_wdata;
    logic [N-1:0][3:0]   req_wstrb;
    logic [N-1:0]        req_ready;
    logic [31:0]         req_rdata;
    logic                nmi_valid;
    logic [31:0]         nmi_addr;
    logic [31:0]         nmi_wdata;
    logic [3:0]          nmi_wstrb;
    logic                nmi_ready;
    logic [31:0]         nmi_rdata;
    logic                timeout;
    logic                busy;

    int total = 0;
    int fails = 0;
    int cyc   = 0;
    int model_last;
    int t_sample;
    int rdy_cyc [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nmi_rr_arbiter #(
        .N           (N),
        .TIMEOUT_CYC (TO),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .req_ready_o (req_ready),
        .req_rdata_o (req_rdata),
        .nmi_valid_o (nmi_valid),
        .nmi_addr_o  (nmi_addr),
        .nmi_wdata_o (nmi_wdata),
        .nmi_wstrb_o (nmi_wstrb),
        .nmi_ready_i (nmi_ready),
        .nmi_rdata_i (nmi_rdata),
        .timeout_o   (timeout),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(nmi_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rdata"}, req_rdata, 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            req_addr[GW'(i)]  = $urandom;
            req_wdata[GW'(i)] = $urandom;
            req_wstrb[GW'(i)] = 4'($urandom);
        end
    endtask

    // One whole transaction: idle arbitration cycle, then BUSY cycles until the
    // slave answers on BUSY cycle w+1 or the timeout fires on BUSY cycle TO.
    task automatic do_txn(input logic [N-1:0] vmask, input int w, input logic [31:0] rd,
                          input bit mutate, output int win);
        logic [GW-1:0] wi;
        logic [31:0]   ea, ewd;
        logic [3:0]    ews;
        logic          rdy, done;
        int            idx;
        req_valid = vmask;
        nmi_ready = 1'b0;
        @(negedge clk);
        t_sample = cyc;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_nmi_valid", 32'(nmi_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd0);
        chk("idle_rdata", req_rdata, 32'd0);
        win = -1;
        for (int i = 1; i <= N; i++) begin
            idx = (model_last + i) % N;
            if (win < 0 && ((vmask >> idx) & 1) != 0) win = idx;
        end
        wi  = GW'(win);
        ea  = req_addr[wi];
        ewd = req_wdata[wi];
        ews = req_wstrb[wi];
        @(posedge clk); #1;
        if (mutate) begin
            req_valid = N'($urandom);
            rand_payload();
        end
        done = 1'b0;
        for (int k = 1; k <= int'(TO) && !done; k++) begin
            rdy = (k == w + 1);
            nmi_ready = rdy;
            nmi_rdata = rd;
            @(negedge clk);
            chk("busy_valid", 32'(nmi_valid), 32'd1);
            chk("busy_flag", 32'(busy), 32'd1);
            chk("busy_addr", nmi_addr, ea);
            chk("busy_wdata", nmi_wdata, ewd);
            chk("busy_wstrb", 32'(nmi_wstrb), 32'(ews));
            done = rdy || (k == int'(TO));
            chk("req_ready", 32'(req_ready), done ? 32'(N'(1) << wi) : 32'd0);
            chk("req_rdata", req_rdata, !done ? 32'd0 : (rdy ? rd : 32'hDEAD_BEEF));
            chk("timeout", 32'(timeout), 32'(done && !rdy));
            if (done && req_ready[wi]) rdy_cyc[win] = cyc;
            @(posedge clk); #1;
        end
        nmi_ready  = 1'b0;
        model_last = win;
    endtask

    initial begin
        int win;
        int prev;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        nmi_ready = 1'b0;
        nmi_rdata = '0;
        model_last = N - 1;
        for (int i = 0; i < N; i++) rdy_cyc[i] = 0;
        #1;
        chk_all_zero("reset");
        chk("reset_addr", nmi_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention fairness, zero-wait slave
        rand_payload();
        for (int i = 0; i < 6; i++) begin
            prev = rdy_cyc[i % 2];
            do_txn(2'b11, 0, $urandom, 1'b0, win);
            if (i >= 2) chk("fair_period", 32'(rdy_cyc[win] - prev), 32'd4);
        end

        // Single read from requester 0, ready on BUSY cycle 3
        req_addr[0]  = 32'h0300_0010;
        req_wstrb[0] = 4'b0000;
        do_txn(2'b01, 2, 32'h1234_5678, 1'b0, win);
        chk("read_latency", 32'(rdy_cyc[0] - t_sample), 32'd3);

        // Write latch: requester 1 changes its payload after the grant
        req_addr[1]  = 32'h0300_0020;
        req_wdata[1] = 32'hA5A5_A5A5;
        req_wstrb[1] = 4'b0011;
        do_txn(2'b10, 2, 32'h0, 1'b1, win);

        // Timeout, slave never ready
        do_txn(2'b01, 10, 32'h5555_AAAA, 1'b0, win);
        req_valid = '0;
        @(negedge clk);
        chk("post_timeout_valid", 32'(nmi_valid), 32'd0);
        chk("post_timeout_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Ready on the same cycle the timeout would fire
        do_txn(2'b11, int'(TO) - 1, 32'hC0DE_0004, 1'b0, win);

        // Reset in the middle of a transaction
        req_valid = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        chk("midreset_addr", nmi_addr, 32'd0);
        chk("midreset_wdata", nmi_wdata, 32'd0);
        chk("midreset_wstrb", 32'(nmi_wstrb), 32'd0);
        @(negedge clk);
        chk("inreset_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        model_last = N - 1;
        do_txn(2'b11, 1, $urandom, 1'b0, win);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            rand_payload();
            do_txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 5)),
                   $urandom, 1'($urandom_range(0, 1)), win);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
